// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings and default latencies.
package mdu_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/mdu_divider.sv
// Combinational 32-bit signed/unsigned divider producing quotient, remainder and a divide-by-zero flag.
module mdu_divider (
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  input  logic        signed_i,
  output logic [31:0] quot_o,
  output logic [31:0] rem_o,
  output logic        div_zero_o
);

  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, q_mag, r_mag;

  // Divide magnitudes, then restore signs. 0x80000000 / -1 falls out naturally:
  // |a| = 2^31 as unsigned, quotient sign is positive, so lo wraps to 0x80000000.
  assign a_neg      = signed_i & dividend_i[31];
  assign b_neg      = signed_i & divisor_i[31];
  assign a_mag      = a_neg ? (~dividend_i + 32'd1) : dividend_i;
  assign b_mag      = b_neg ? (~divisor_i + 32'd1) : divisor_i;
  assign div_zero_o = (divisor_i == 32'd0);
  assign q_mag      = div_zero_o ? 32'd0 : (a_mag / b_mag);
  assign r_mag      = div_zero_o ? 32'd0 : (a_mag % b_mag);
  assign quot_o     = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
  assign rem_o      = a_neg ? (~r_mag + 32'd1) : r_mag;

endmodule

// File: rtl/muldiv_unit.sv
// MIPS E-stage multiply/divide unit: latches a result at start, holds busy for a fixed latency,
// then commits it to the architectural HI/LO registers.
module muldiv_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        hi_q, hi_d, lo_q, lo_d;
  logic [63:0]        pend_q, pend_d;
  logic               pend_wr_q, pend_wr_d;

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        quot, rem;
  logic               div_zero;

  assign prod_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
  assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};

  mdu_divider u_div (
    .dividend_i (rs_val),
    .divisor_i  (rt_val),
    .signed_i   (op == MD_DIV),
    .quot_o     (quot),
    .rem_o      (rem),
    .div_zero_o (div_zero)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_d    = pend_q;
    pend_wr_d = pend_wr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            MD_MULT, MD_MULTU: begin
              pend_d    = (op == MD_MULT) ? prod_s : prod_u;
              pend_wr_d = 1'b1;
              cnt_d     = CNT_W'(MULT_CYCLES);
              state_d   = S_RUN;
            end
            MD_DIV, MD_DIVU: begin
              // A zero divisor still occupies the unit but leaves HI/LO untouched.
              pend_d    = {rem, quot};
              pend_wr_d = ~div_zero;
              cnt_d     = CNT_W'(DIV_CYCLES);
              state_d   = S_RUN;
            end
            MD_MTHI: hi_d = rs_val;
            MD_MTLO: lo_d = rs_val;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_IDLE;
          if (pend_wr_q) begin
            hi_d = pend_q[63:32];
            lo_d = pend_q[31:0];
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  // Pending data needs no reset: it is only consumed when the FSM commits.
  always_ff @(posedge clk) begin
    pend_q <= pend_d;
  end

  assign busy = (state_q == S_RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit against an arithmetic HI/LO reference model.
module tb_muldiv_unit;
  import mdu_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        busy;
  logic [31:0] hi, lo;

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] exp_hi, exp_lo;

  muldiv_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Architectural effect of one operation, from plain 64-bit arithmetic.
  task automatic ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] nh, output logic [31:0] nl, output int lat);
    longint          sa, sb, sp;
    longint unsigned ua, ub, up;
    nh  = exp_hi;
    nl  = exp_lo;
    lat = 0;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    case (o)
      3'd0: begin sp = sa * sb; nh = sp[63:32]; nl = sp[31:0]; lat = MC; end
      3'd1: begin up = ua * ub; nh = up[63:32]; nl = up[31:0]; lat = MC; end
      3'd2: begin
        lat = DC;
        if (b != 0) begin sp = sa / sb; nl = sp[31:0]; sp = sa % sb; nh = sp[31:0]; end
      end
      3'd3: begin
        lat = DC;
        if (b != 0) begin up = ua / ub; nl = up[31:0]; up = ua % ub; nh = up[31:0]; end
      end
      3'd4: nh = a;
      3'd5: nl = a;
      default: ;
    endcase
  endtask

  // Issue one op; inj>0 pulses a stray MTHI on that busy cycle, which must be ignored.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int inj, input string tag);
    logic [31:0] nh, nl;
    int          lat, n;
    ref_model(o, a, b, nh, nl, lat);
    @(negedge clk);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    @(negedge clk);
    start = 1'b0;
    if (lat == 0) begin
      chk({tag, " busy"}, busy, 1'b0);
    end else begin
      n = 0;
      while (busy === 1'b1 && n < lat + 8) begin
        chk({tag, " hi held"}, hi, exp_hi);
        chk({tag, " lo held"}, lo, exp_lo);
        n++;
        if (n == inj) begin
          start = 1'b1; op = MD_MTHI; rs_val = 32'hDEADBEEF;
        end
        @(negedge clk);
        start = 1'b0;
      end
      chk({tag, " busy cycles"}, n, lat);
    end
    chk({tag, " hi"}, hi, nh);
    chk({tag, " lo"}, lo, nl);
    exp_hi = nh;
    exp_lo = nl;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  o;
    logic [31:0] a, b;
    int          sel;
    reset = 1'b1; start = 1'b0; op = '0; rs_val = '0; rt_val = '0;
    exp_hi = '0; exp_lo = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset busy", busy, 1'b0);
    chk("reset hi", hi, 32'h0);
    chk("reset lo", lo, 32'h0);

    run_op(MD_MULT, 32'hFFFFFFFD, 32'd5, 0, "mult");
    chk("mult hi const", hi, 32'hFFFFFFFF);
    chk("mult lo const", lo, 32'hFFFFFFF1);
    run_op(MD_MULTU, 32'hFFFFFFFF, 32'd2, 0, "multu");
    chk("multu hi const", hi, 32'h00000001);
    chk("multu lo const", lo, 32'hFFFFFFFE);
    run_op(MD_DIV, 32'hFFFFFFF9, 32'd2, 0, "div");
    chk("div lo const", lo, 32'hFFFFFFFD);
    chk("div hi const", hi, 32'hFFFFFFFF);
    run_op(MD_MTHI, 32'h12345678, 32'd0, 0, "mthi");
    run_op(MD_MTLO, 32'h9ABCDEF0, 32'd0, 0, "mtlo");
    run_op(MD_DIVU, 32'd1000, 32'd0, 0, "divu0");
    chk("divu0 hi const", hi, 32'h12345678);
    chk("divu0 lo const", lo, 32'h9ABCDEF0);
    run_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 0, "divovf");
    chk("divovf lo const", lo, 32'h80000000);
    chk("divovf hi const", hi, 32'h00000000);
    run_op(MD_MULT, 32'h00012345, 32'hFFFF0003, 2, "mult inj");

    for (int i = 0; i < 40; i++) begin
      o   = 3'($urandom_range(0, 7));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) b = 32'd0;
      else if (sel == 1) b = 32'($urandom_range(1, 7));
      else if (sel == 2) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
      else if (sel == 3) a = 32'($urandom_range(0, 20));
      run_op(o, a, b, (sel == 4) ? 1 : 0, "rand");
    end

    // Reset on busy cycle 4 of a DIV must abort it with no later commit.
    @(negedge clk);
    start = 1'b1; op = MD_DIV; rs_val = 32'd100; rt_val = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort busy before", busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort busy", busy, 1'b0);
    chk("abort hi", hi, 32'h0);
    chk("abort lo", lo, 32'h0);
    repeat (DC + 3) @(negedge clk);
    chk("abort busy later", busy, 1'b0);
    chk("abort hi later", hi, 32'h0);
    chk("abort lo later", lo, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Multiply/divide responder for the E-stage Start/Busy handshake of the 5-stage MIPS pipeline. It accepts MULT, MULTU, DIV, DIVU, MTHI and MTLO from the EX stage and holds the architectural HI/LO registers. It raises busy for a fixed multi-cycle latency so the hazard unit can stall HI/LO-dependent instructions in D. MFHI and MFLO read the hi and lo outputs combinationally in E.

Parameters:
MULT_CYCLES, 5, number of cycles busy stays high for MULT/MULTU (legal range 1 or more)
DIV_CYCLES, 10, number of cycles busy stays high for DIV/DIVU (legal range 1 or more)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle pulse; op, rs_val and rt_val are valid while it is high
op  in  3  operation code, defined in the package
rs_val  in  32  forwarded rs operand (dividend or multiplicand; source for MTHI/MTLO)
rt_val  in  32  forwarded rt operand (divisor or multiplier)
busy  out  1  a mult/div operation is in flight
hi  out  32  architectural HI register
lo  out  32  architectural LO register

Behaviour:
- Reset (synchronous, active-high, clock clk):
  - busy=0, hi=0, lo=0, cycle counter=0.
  - Any pending result is discarded. This includes reset arriving mid-operation: no commit afterwards.
- States: IDLE and RUN.
- IDLE with start=1 and op in {MULT, MULTU, DIV, DIVU}:
  - Latch the full 64-bit result into a pending register during cycle t.
  - Load the counter with MULT_CYCLES or DIV_CYCLES and go to RUN.
  - busy is high for cycles t+1 through t+N.
  - On the edge ending cycle t+N, hi/lo take the pending result and busy falls, so the new values are visible from cycle t+N+1.
- IDLE with start=1 and op=MTHI: hi<=rs_val at the next edge. busy stays 0. lo is unchanged.
- IDLE with start=1 and op=MTLO: lo<=rs_val at the next edge. busy stays 0. hi is unchanged.
- IDLE with start=1 and op=6 or 7 (reserved): ignored.
- RUN:
  - Counter decrements each cycle; at count 1 commit and return to IDLE.
  - start is ignored in RUN (the hazard unit guarantees it does not occur). HI/LO are not disturbed and no new operation is latched.
- hi and lo hold their old values throughout RUN. They change only at the commit edge.
- Arithmetic:
  - MULT: signed 32x32 to 64 bits. hi=[63:32], lo=[31:0].
  - MULTU: the same, unsigned.
  - DIV: signed, quotient truncated toward zero. lo=quotient, hi=remainder; the remainder takes the sign of the dividend.
  - DIVU: unsigned. lo=quotient, hi=remainder.
- Division boundaries:
  - Divisor 0 (DIV or DIVU): the unit still runs the full DIV_CYCLES with busy high, but hi and lo keep their previous values at the commit edge.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. No trap.
- The block has no flush input. An operation that started always completes unless reset intervenes.

Decomposition:
- Shared package (mdu_pkg):
  - op encodings: MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3, MD_MTHI=4, MD_MTLO=5.
  - Default latency constants (5 and 10).
- One natural sub-module: mdu_divider.
  - Combinational signed/unsigned 32-bit quotient and remainder.
  - Handles the sign fix-ups, divide-by-zero flag and overflow case.
  - The top level keeps the FSM, counter, pending register and HI/LO.

Test Plan:
- Reset, then start MULT with rs=0xFFFFFFFD (-3), rt=5:
  - busy is high for exactly 5 cycles after the start cycle.
  - After it falls, hi=0xFFFFFFFF and lo=0xFFFFFFF1.
  - hi/lo stay 0 while busy.
- MULTU with rs=0xFFFFFFFF, rt=2: after 5 busy cycles, hi=0x00000001 and lo=0xFFFFFFFE.
- DIV with rs=0xFFFFFFF9 (-7), rt=2: after 10 busy cycles, lo=0xFFFFFFFD and hi=0xFFFFFFFF.
- DIVU with rt=0 after MTHI 0x12345678 and MTLO 0x9ABCDEF0:
  - Each MT updates its register one cycle later with busy=0.
  - The DIVU then shows busy for 10 cycles and hi/lo keep 0x12345678 and 0x9ABCDEF0.
- DIV with rs=0x80000000, rt=0xFFFFFFFF: lo=0x80000000 and hi=0x00000000.
- Robustness:
  - During a MULT, pulse start with MTHI on cycle 2 of busy: the pulse is ignored, busy stays exactly 5 cycles and the MULT result commits.
  - Start a DIV, then assert reset on busy cycle 4: busy=0, hi=0 and lo=0 next cycle, with no later commit.
